// File: rtl/player_ctl_if.sv
// player_ctl_if: frame sync, button levels and sprite position exchanged with player_ctl.
interface player_ctl_if;
    logic       vblnk;
    logic       move_left;
    logic       move_right;
    logic       jump;
    logic [9:0] player_xpos;
    logic [9:0] player_ypos;
    logic       on_ground;
    modport master (
        output vblnk, move_left, move_right, jump,
        input  player_xpos, player_ypos, on_ground
    );
    modport slave (
        input  vblnk, move_left, move_right, jump,
        output player_xpos, player_ypos, on_ground
    );
endinterface

// File: rtl/player_ctl.sv
// player_ctl: per-frame player sprite position from buttons; walk clamp plus jump/gravity FSM.
// Optional PLAYER_DOUBLE_JUMP_EN allows one extra jump while airborne.
module player_ctl #(
    parameter int X_START  = 10,
    parameter int X_MAX    = 958,
    parameter int GROUND_Y = 292,
    parameter int STEP     = 4,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 12
) (
    input logic         clk,
    input logic         rst,
    player_ctl_if.slave bus
);
    typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;
    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [4:0]  v_q, v_d;
    logic        vblnk_prev_q, jump_prev_q, jump_req_q, jump_req_d, on_ground_q;
    logic        tick, req, dbl_fire;
    logic [9:0]  x_left, x_right, y_rise;
    logic [10:0] x_sum, y_fall;
    logic [5:0]  v_sum;
    logic [4:0]  v_rise, v_fall;
    assign tick       = bus.vblnk & ~vblnk_prev_q;
    // a jump edge coinciding with the tick still counts for that tick
    assign req        = jump_req_q | (bus.jump & ~jump_prev_q);
    assign jump_req_d = tick ? 1'b0 : req;
    assign x_left  = (x_q < 10'(STEP)) ? 10'd0 : x_q - 10'(STEP);
    assign x_sum   = {1'b0, x_q} + 11'(STEP);
    assign x_right = (x_sum > 11'(X_MAX)) ? 10'(X_MAX) : x_sum[9:0];
    assign x_d     = !tick ? x_q :
                     (bus.move_left && !bus.move_right) ? x_left :
                     (bus.move_right && !bus.move_left) ? x_right : x_q;
    assign y_rise  = (y_q < 10'(v_q)) ? 10'd0 : y_q - 10'(v_q);
    assign v_rise  = v_q - 5'(GRAVITY);
    assign v_sum   = {1'b0, v_q} + 6'(GRAVITY);
    assign v_fall  = (v_sum > 6'(MAX_FALL)) ? 5'(MAX_FALL) : v_sum[4:0];
    assign y_fall  = {1'b0, y_q} + 11'(v_fall);
`ifdef PLAYER_DOUBLE_JUMP_EN
    logic dbl_used_q, dbl_used_d;
    assign dbl_fire   = tick & req & ~dbl_used_q & (state_q == RISE || state_q == FALL);
    assign dbl_used_d = (state_d == GROUND) ? 1'b0 : (dbl_fire | dbl_used_q);
    always_ff @(posedge clk) begin
        if (rst) dbl_used_q <= 1'b0;
        else     dbl_used_q <= dbl_used_d;
    end
`else
    assign dbl_fire = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        v_d     = v_q;
        case (state_q)
            GROUND: begin
                if (tick && req) begin
                    state_d = RISE;
                    v_d     = 5'(JUMP_V);
                end
            end
            RISE: begin
                if (dbl_fire) begin
                    v_d = 5'(JUMP_V);
                end else if (tick) begin
                    y_d     = y_rise;
                    v_d     = v_rise;
                    state_d = (v_rise == 5'd0) ? FALL : RISE;
                end
            end
            FALL: begin
                if (dbl_fire) begin
                    v_d     = 5'(JUMP_V);
                    state_d = RISE;
                end else if (tick) begin
                    y_d     = (y_fall >= 11'(GROUND_Y)) ? 10'(GROUND_Y) : y_fall[9:0];
                    v_d     = (y_fall >= 11'(GROUND_Y)) ? 5'd0 : v_fall;
                    state_d = (y_fall >= 11'(GROUND_Y)) ? GROUND : FALL;
                end
            end
            default: begin
                state_d = GROUND;
                y_d     = 10'(GROUND_Y);
                v_d     = 5'd0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= GROUND;
            x_q          <= 10'(X_START);
            y_q          <= 10'(GROUND_Y);
            v_q          <= 5'd0;
            vblnk_prev_q <= 1'b0;
            jump_prev_q  <= 1'b0;
            jump_req_q   <= 1'b0;
            on_ground_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            v_q          <= v_d;
            vblnk_prev_q <= bus.vblnk;
            jump_prev_q  <= bus.jump;
            jump_req_q   <= jump_req_d;
            on_ground_q  <= (state_d == GROUND);
        end
    end
    assign bus.player_xpos = x_q;
    assign bus.player_ypos = y_q;
    assign bus.on_ground   = on_ground_q;
endmodule

// File: tb/tb_player_ctl.sv
// tb_player_ctl: scoreboard bench; expected positions queued per frame, checked by a tick monitor.
module tb_player_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    player_ctl_if bus();
    player_ctl dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct packed {logic [9:0] x; logic [9:0] y; logic og;} exp_t;
    exp_t  q[$];
    string nq[$];
    exp_t  last;
    int    checks = 0;
    int    errors = 0;
    logic  prev_v = 1'b0;
    logic  t;
    int    jy[25] = '{292, 280, 269, 259, 250, 242, 235, 229, 224, 220, 217, 215, 214,
                      215, 217, 220, 224, 229, 235, 242, 250, 259, 269, 280, 292};
    function automatic exp_t mk(int x, int y, bit og);
        return {10'(x), 10'(y), og};
    endfunction
    task automatic cmp(string name, exp_t e);
        checks++;
        if ({bus.player_xpos, bus.player_ypos, bus.on_ground} !== e) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d og=%0b, want x=%0d y=%0d og=%0b", name,
                     bus.player_xpos, bus.player_ypos, bus.on_ground, e.x, e.y, e.og);
        end
    endtask
    // monitor: the DUT presents a new position one edge after each vblnk rise
    always @(posedge clk) begin
        t      = bus.vblnk & ~prev_v & ~rst;
        prev_v = rst ? 1'b0 : bus.vblnk;
        if (t) begin
            #1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tick_unexpected: got x=%0d y=%0d, want no tick", bus.player_xpos, bus.player_ypos);
            end else begin
                cmp(nq.pop_front(), q.pop_front());
            end
        end
    end
    task automatic frame(string name, int x, int y, bit og);
        @(negedge clk);
        bus.vblnk = 1'b1;
        #1 cmp({name, "_hold"}, last);
        last = mk(x, y, og);
        q.push_back(last);
        nq.push_back(name);
        @(negedge clk);
        @(negedge clk);
        bus.vblnk = 1'b0;
    endtask
    task automatic pulse();
        @(negedge clk);
        bus.jump = 1'b1;
        @(negedge clk);
        bus.jump = 1'b0;
    endtask
    task automatic jump_frames(string name, int from, int to);
        for (int k = from; k <= to; k++) frame(name, 958, jy[k], k == 24);
    endtask
    initial begin
        bus.vblnk = 1'b0;
        bus.move_left = 1'b0;
        bus.move_right = 1'b0;
        bus.jump = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last = mk(10, 292, 1);
        #1 cmp("reset", last);
        repeat (100) @(negedge clk);
        #1 cmp("no_tick_hold", last);
        bus.move_right = 1'b1;
        for (int k = 1; k <= 5; k++) frame("walk_right", 10 + 4 * k, 292, 1);
        bus.move_left = 1'b1;
        for (int k = 0; k < 3; k++) frame("both_held", 30, 292, 1);
        bus.move_right = 1'b0;
        for (int k = 1; k <= 7; k++) frame("walk_left", 30 - 4 * k, 292, 1);
        frame("clamp_left", 0, 292, 1);
        frame("clamp_left_hold", 0, 292, 1);
        bus.move_left = 1'b0;
        bus.move_right = 1'b1;
        for (int k = 1; k <= 239; k++) frame("walk_to_edge", 4 * k, 292, 1);
        frame("clamp_right", 958, 292, 1);
        frame("clamp_right_hold", 958, 292, 1);
        frame("clamp_right_hold2", 958, 292, 1);
        bus.move_right = 1'b0;
        pulse();
        jump_frames("jump", 0, 24);
        @(negedge clk);
        bus.jump = 1'b1;
        jump_frames("jump_held", 0, 24);
        for (int k = 0; k < 3; k++) frame("held_no_rejump", 958, 292, 1);
        @(negedge clk);
        bus.jump = 1'b0;
        pulse();
        jump_frames("apex_jump", 0, 12);
        pulse();
`ifdef PLAYER_DOUBLE_JUMP_EN
        frame("dbl_takeoff", 958, 214, 0);
        for (int k = 1; k <= 24; k++) begin
            frame("dbl_arc", 958, jy[k] - 78, 0);
            if (k == 6) pulse();
        end
        for (int k = 1; k <= 6; k++) frame("dbl_fall", 958, 214 + 12 * k, 0);
        frame("dbl_land", 958, 292, 1);
`else
        jump_frames("air_pulse_ignored", 13, 24);
`endif
        pulse();
        jump_frames("rejump", 0, 24);
        pulse();
        jump_frames("pre_reset", 0, 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 cmp("reset_mid_jump", mk(10, 292, 1));
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
